sum_last4_arb: RTL and testbench

Two-channel round-robin scheduler that time-shares a single last-4 sliding-sum engine between two sample producers. Each channel keeps its own 3-deep history of previously accepted samples. The single adder produces the sum of the channel's current sample plus its last three samples. The block sits between two sample sources and a downstream consumer of tagged window sums.

---
 rtl/sum_last4_arb.sv | 128 ++++++++++++
 tb/tb_sum_last4_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_last4_arb.sv
// Two-channel round-robin front end sharing one last-4 window-sum adder.
// Optional macro WIN_AVG_EN adds a registered floor(sum/4) output avg.
module sum_last4_arb #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    input  logic          flush,
    output logic          gnt0,
    output logic          gnt1,
    output logic          busy,
    output logic          out_valid,
    output logic          out_ch,
`ifdef WIN_AVG_EN
    output logic [DW-1:0] avg,
`endif
    output logic [DW+1:0] out
);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                 prio;
    logic                 sel;
    logic [DW-1:0]        cur;
    logic [2:0][DW-1:0]   hist0;
    logic [2:0][DW-1:0]   hist1;
    logic [2:0][DW-1:0]   hsel;
    logic [DW+1:0]        sum;

    // State register; reset returns to IDLE and drops any pending sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration and next state; grants only in IDLE, never during flush.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            IDLE: begin
                if (reset && !flush) begin
                    if (req0 && (!req1 || !prio)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                    if (gnt0 || gnt1) begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == CALC);

    // Single shared adder over the selected channel's history plus cur.
    always_comb begin
        hsel = sel ? hist1 : hist0;
        sum  = {2'b00, hsel[0]} + {2'b00, hsel[1]}
             + {2'b00, hsel[2]} + {2'b00, cur};
    end

    // Capture on grant, produce result and shift history in CALC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio      <= 1'b0;
            sel       <= 1'b0;
            cur       <= '0;
            hist0     <= '0;
            hist1     <= '0;
            out       <= '0;
            out_ch    <= 1'b0;
            out_valid <= 1'b0;
`ifdef WIN_AVG_EN
            avg       <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                hist0 <= '0;
                hist1 <= '0;
                out   <= '0;
`ifdef WIN_AVG_EN
                avg   <= '0;
`endif
            end else if (gnt0 || gnt1) begin
                cur  <= gnt1 ? data1 : data0;
                sel  <= gnt1;
                prio <= ~gnt1;
            end else if (state == CALC) begin
                out       <= sum;
                out_ch    <= sel;
                out_valid <= 1'b1;
`ifdef WIN_AVG_EN
                avg       <= sum[DW+1:2];
`endif
                if (sel) begin
                    hist1 <= {hist1[1:0], cur};
                end else begin
                    hist0 <= {hist0[1:0], cur};
                end
            end
        end
    end

endmodule

// File: tb/tb_sum_last4_arb.sv
// Directed bench for sum_last4_arb with a result scoreboard.
// Expected sums come from a per-channel history model in the bench.
module tb_sum_last4_arb;

    localparam int DW = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          req0  = 1'b0;
    logic          req1  = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] data0 = '0;
    logic [DW-1:0] data1 = '0;
    logic          gnt0;
    logic          gnt1;
    logic          busy;
    logic          out_valid;
    logic          out_ch;
    logic [DW+1:0] out;
`ifdef WIN_AVG_EN
    logic [DW-1:0] avg;
`endif

    typedef struct {
        logic ch;
        int   sum;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   mh0[3];
    int   mh1[3];
    logic pend   = 1'b0;

    sum_last4_arb #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .flush     (flush),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ch    (out_ch),
`ifdef WIN_AVG_EN
        .avg       (avg),
`endif
        .out       (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clr_model();
        for (int i = 0; i < 3; i++) begin
            mh0[i] = 0;
            mh1[i] = 0;
        end
    endtask

    task automatic push(input logic ch, input int d);
        exp_t e;
        e.ch  = ch;
        e.cyc = cyc;
        if (ch) begin
            e.sum  = mh1[0] + mh1[1] + mh1[2] + d;
            mh1[2] = mh1[1];
            mh1[1] = mh1[0];
            mh1[0] = d;
        end else begin
            e.sum  = mh0[0] + mh0[1] + mh0[2] + d;
            mh0[2] = mh0[1];
            mh0[1] = mh0[0];
            mh0[0] = d;
        end
        q.push_back(e);
    endtask

    // Scoreboard: check results, then track flush/reset, then log grants.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            chk("valid_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out", out, e.sum);
                chk("out_ch", out_ch, e.ch);
                chk("latency", cyc - e.cyc, 2);
`ifdef WIN_AVG_EN
                chk("avg", avg, e.sum >> 2);
`endif
            end
        end
        if (!reset) begin
            q.delete();
            clr_model();
            pend = 1'b0;
        end else if (flush) begin
            if (pend && q.size() > 0) e = q.pop_back();
            clr_model();
            pend = 1'b0;
        end else begin
            pend = 1'b0;
        end
        if (reset && !flush && gnt0) begin
            push(1'b0, int'(data0));
            pend = 1'b1;
        end else if (reset && !flush && gnt1) begin
            push(1'b1, int'(data1));
            pend = 1'b1;
        end
    end

    task automatic wait_gnt(input logic ch);
        logic got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((ch ? gnt1 : gnt0) === 1'b1) got = 1'b1;
        end
        chk("gnt_wait", got, 1);
    endtask

    task automatic send(input logic ch, input logic [DW-1:0] d);
        @(posedge clk); #1;
        if (ch) begin
            req1  = 1'b1;
            data1 = d;
        end else begin
            req0  = 1'b1;
            data0 = d;
        end
        wait_gnt(ch);
        @(posedge clk); #1;
        if (ch) req1 = 1'b0;
        else req0 = 1'b0;
        @(negedge clk);
        chk("busy_t1", busy, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
        chk("drain_q", q.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] v1[6];
        int            gch[4];
        int            gcy[4];
        int            n;

        clr_model();
        v1 = '{8'd100, 8'd100, 8'd0, 8'd50, 8'd50, 8'd250};

        // Reset state; gnt0 must stay low with req0 high during reset.
        req0  = 1'b1;
        data0 = 8'd55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_ch", out_ch, 0);
        @(posedge clk); #1;
        req0  = 1'b0;
        reset = 1'b1;

        // Channel 0 only sliding sums.
        for (int i = 0; i < 6; i++) send(1'b0, v1[i]);
        drain();
        chk("t1_out", out, 350);
        chk("t1_ch", out_ch, 0);

        // Both channels continuously requesting.
        do_reset();
        req0  = 1'b1;
        data0 = 8'd10;
        req1  = 1'b1;
        data1 = 8'd20;
        n = 0;
        for (int i = 0; i < 12 && n < 4; i++) begin
            @(negedge clk);
            chk("one_hot", gnt0 & gnt1, 0);
            if (gnt0) begin
                gch[n] = 0;
                gcy[n] = cyc;
                n++;
            end else if (gnt1) begin
                gch[n] = 1;
                gcy[n] = cyc;
                n++;
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        chk("n_grants", n, 4);
        for (int k = 0; k < n; k++) begin
            chk("order", gch[k], k % 2);
            if (k > 0) chk("spacing", gcy[k] - gcy[k-1], 2);
        end
        drain();
        chk("t2_out", out, 40);
        chk("t2_ch", out_ch, 1);

        // Saturating inputs, widest sum.
        do_reset();
        for (int i = 0; i < 4; i++) send(1'b0, 8'd255);
        send(1'b0, 8'd0);
        drain();
        chk("t3_out", out, 765);

        // Flush in the CALC cycle discards the pending result.
        do_reset();
        send(1'b0, 8'd9);
        @(posedge clk); #1;
        req0  = 1'b1;
        data0 = 8'd7;
        wait_gnt(1'b0);
        @(posedge clk); #1;
        req0  = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("t4_busy", busy, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("t4_valid", out_valid, 0);
        chk("t4_out", out, 0);
        send(1'b0, 8'd5);
        drain();
        chk("t4_after", out, 5);

        // Flush held in IDLE blocks the grant.
        send(1'b1, 8'd50);
        drain();
        @(posedge clk); #1;
        flush = 1'b1;
        req1  = 1'b1;
        data1 = 8'd33;
        repeat (3) begin
            @(negedge clk);
            chk("t5_gnt1", gnt1, 0);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        wait_gnt(1'b1);
        @(posedge clk); #1;
        req1 = 1'b0;
        drain();
        chk("t5_out", out, 33);
        chk("t5_ch", out_ch, 1);

        // Reset in CALC; prio and histories restart.
        send(1'b1, 8'd60);
        @(posedge clk); #1;
        req0  = 1'b1;
        data0 = 8'd40;
        wait_gnt(1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        req1  = 1'b1;
        data1 = 8'd3;
        @(negedge clk);
        chk("t6_gnt0_rst", gnt0, 0);
        chk("t6_gnt1_rst", gnt1, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_out", out, 0);
        chk("t6_ch", out_ch, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_gnt0", gnt0, 1);
        chk("t6_gnt1", gnt1, 0);
        @(posedge clk); #1;
        req0 = 1'b0;
        wait_gnt(1'b1);
        @(posedge clk); #1;
        req1 = 1'b0;
        drain();
        chk("t6_last", out, 3);
        chk("t6_last_ch", out_ch, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
